// File: rtl/cp0_exc_ctrl.sv
// CP0 exception controller: Status/Cause/EPC, Count/Compare timer, external interrupts,
// SYSCALL/ERET handling with a registered one-cycle PC redirect and MFC0/MTC0 access.
module cp0_exc_ctrl #(
   parameter int          HW_INTS     = 6,
   parameter int          SYNC_STAGES = 2,
   parameter logic [31:0] EXC_VECTOR  = 32'h0000_3000,
   parameter logic [31:0] EPC_RESET   = 32'h0000_3000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               instr_valid,
   input  logic [31:0]        pc_cur,
   input  logic               mtc0,
   input  logic               syscall,
   input  logic               eret,
   input  logic [4:0]         reg_num,
   input  logic [31:0]        din,
   output logic [31:0]        dout,
   input  logic [HW_INTS-1:0] hw_int,
   output logic               redirect,
   output logic [31:0]        redirect_pc,
   output logic               timer_irq
);

   logic [31:0]        count;
   logic [31:0]        compare;
   logic [31:0]        epc;
   logic [7:0]         status_im;
   logic               exl;
   logic               ie;
   logic [1:0]         sw_ip;
   logic [4:0]         exc_code;
   logic               timer_ip;
   logic [HW_INTS-1:0] hw_sync;
   logic [5:0]         ip_hi;
   logic [7:0]         ip;
   logic               int_pend;

   generate
      if (SYNC_STAGES == 0) begin : g_bypass
         assign hw_sync = hw_int;
      end else begin : g_sync
         logic [HW_INTS-1:0] stage [SYNC_STAGES];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
            end else begin
               stage[0] <= hw_int;
               for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
            end
         end

         assign hw_sync = stage[SYNC_STAGES-1];
      end
   endgenerate

   // The timer shares Cause bit 15 with the top external line, as on MIPS32.
   always_comb begin
      ip_hi = '0;
      ip_hi[HW_INTS-1:0] = hw_sync;
      ip_hi[5] = ip_hi[5] | timer_ip;
   end

   assign ip        = {ip_hi, sw_ip};
   assign int_pend  = ie & ~exl & (|(ip & status_im));
   assign timer_irq = timer_ip;

   always_comb begin
      dout = '0;
      case (reg_num)
         5'd9:    dout = count;
         5'd11:   dout = compare;
         5'd12:   dout = {16'b0, status_im, 6'b0, exl, ie};
         5'd13:   dout = {16'b0, ip, 1'b0, exc_code, 2'b0};
         5'd14:   dout = epc;
         default: dout = '0;
      endcase
   end

   // One action per committing instruction; a pending interrupt pre-empts the instruction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count       <= '0;
         compare     <= '0;
         epc         <= EPC_RESET;
         status_im   <= '0;
         exl         <= 1'b0;
         ie          <= 1'b0;
         sw_ip       <= '0;
         exc_code    <= '0;
         timer_ip    <= 1'b0;
         redirect    <= 1'b0;
         redirect_pc <= '0;
      end else begin
         count    <= count + 32'd1;
         redirect <= 1'b0;
         if (compare != 32'd0 && count == compare) timer_ip <= 1'b1;
         if (instr_valid) begin
            if (int_pend) begin
               epc         <= pc_cur;
               exc_code    <= 5'd0;
               exl         <= 1'b1;
               redirect    <= 1'b1;
               redirect_pc <= EXC_VECTOR;
            end else if (syscall) begin
               epc         <= pc_cur;
               exc_code    <= 5'd8;
               exl         <= 1'b1;
               redirect    <= 1'b1;
               redirect_pc <= EXC_VECTOR;
            end else if (eret) begin
               exl         <= 1'b0;
               redirect    <= 1'b1;
               redirect_pc <= epc;
            end else if (mtc0) begin
               case (reg_num)
                  5'd9:  count <= din;
                  5'd11: begin
                     compare  <= din;
                     timer_ip <= 1'b0;
                  end
                  5'd12: begin
                     status_im <= din[15:8];
                     exl       <= din[1];
                     ie        <= din[0];
                  end
                  5'd13:   sw_ip <= din[9:8];
                  5'd14:   epc   <= din;
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: a vector table for register/priority behaviour
// plus hand sequences for reset, timer, synchroniser latency and Count wrap.
module tb_cp0_exc_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_valid = 1'b0;
   logic [31:0] pc_cur = '0;
   logic        mtc0 = 1'b0;
   logic        syscall = 1'b0;
   logic        eret = 1'b0;
   logic [4:0]  reg_num = '0;
   logic [31:0] din = '0;
   logic [31:0] dout;
   logic [5:0]  hw_int = '0;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        timer_irq;

   int applied = 0;
   int miscompares = 0;

   typedef struct {
      logic        iv;
      logic        m;
      logic        s;
      logic        e;
      logic [4:0]  rn;
      logic [31:0] d;
      logic [31:0] pc;
      logic [4:0]  chk_rn;
      logic [31:0] exp_dout;
      logic        exp_redir;
      logic [31:0] exp_rpc;
   } vec_t;

   vec_t vecs [20];

   cp0_exc_ctrl #(
      .HW_INTS(6), .SYNC_STAGES(2),
      .EXC_VECTOR(32'h0000_3000), .EPC_RESET(32'h0000_3000)
   ) dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .pc_cur(pc_cur),
      .mtc0(mtc0), .syscall(syscall), .eret(eret), .reg_num(reg_num), .din(din),
      .dout(dout), .hw_int(hw_int), .redirect(redirect), .redirect_pc(redirect_pc),
      .timer_irq(timer_irq)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      applied++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
      end
   endtask

   task automatic apply_stimulus(input logic iv, input logic m, input logic s, input logic e,
                                 input logic [4:0] rn, input logic [31:0] d, input logic [31:0] pc);
      @(negedge clk);
      instr_valid = iv;
      mtc0        = m;
      syscall     = s;
      eret        = e;
      reg_num     = rn;
      din         = d;
      pc_cur      = pc;
   endtask

   // Wait for the active edge, then drop the commit so later peeks cannot alter state.
   task automatic step();
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      mtc0        = 1'b0;
      syscall     = 1'b0;
      eret        = 1'b0;
   endtask

   task automatic peek(input logic [4:0] rn, output logic [31:0] v);
      reg_num = rn;
      #1;
      v = dout;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   logic [31:0] rd;

   initial begin
      vecs[0]  = '{1, 1, 0, 0, 5'd14, 32'h1234_5678, 32'h0,  5'd14, 32'h1234_5678, 0, 32'h0};
      vecs[1]  = '{1, 1, 0, 0, 5'd12, 32'hFFFF_FFFC, 32'h0,  5'd12, 32'h0000_FF00, 0, 32'h0};
      vecs[2]  = '{1, 1, 0, 0, 5'd13, 32'hFFFF_FFFF, 32'h0,  5'd13, 32'h0000_0300, 0, 32'h0};
      vecs[3]  = '{1, 1, 0, 0, 5'd13, 32'h0,         32'h0,  5'd13, 32'h0,         0, 32'h0};
      vecs[4]  = '{1, 0, 1, 0, 5'd0,  32'h0,         32'h40, 5'd14, 32'h40,        1, 32'h3000};
      vecs[5]  = '{0, 0, 0, 0, 5'd0,  32'h0,         32'h0,  5'd13, 32'h20,        0, 32'h0};
      vecs[6]  = '{0, 0, 0, 0, 5'd0,  32'h0,         32'h0,  5'd12, 32'hFF02,      0, 32'h0};
      vecs[7]  = '{0, 0, 0, 1, 5'd0,  32'h0,         32'h0,  5'd12, 32'hFF02,      0, 32'h0};
      vecs[8]  = '{1, 0, 0, 1, 5'd0,  32'h0,         32'h0,  5'd12, 32'hFF00,      1, 32'h40};
      vecs[9]  = '{0, 0, 0, 0, 5'd0,  32'h0,         32'h0,  5'd14, 32'h40,        0, 32'h0};
      vecs[10] = '{1, 1, 0, 0, 5'd13, 32'h100,       32'h0,  5'd13, 32'h120,       0, 32'h0};
      vecs[11] = '{1, 1, 0, 0, 5'd12, 32'h101,       32'h0,  5'd12, 32'h101,       0, 32'h0};
      vecs[12] = '{1, 0, 1, 0, 5'd0,  32'h0,         32'h50, 5'd13, 32'h100,       1, 32'h3000};
      vecs[13] = '{0, 0, 0, 0, 5'd0,  32'h0,         32'h0,  5'd12, 32'h103,       0, 32'h0};
      vecs[14] = '{1, 0, 1, 0, 5'd0,  32'h0,         32'h60, 5'd14, 32'h60,        1, 32'h3000};
      vecs[15] = '{1, 1, 0, 0, 5'd13, 32'h0,         32'h0,  5'd13, 32'h20,        0, 32'h0};
      vecs[16] = '{1, 1, 0, 0, 5'd3,  32'hDEAD,      32'h0,  5'd3,  32'h0,         0, 32'h0};
      vecs[17] = '{0, 1, 0, 0, 5'd14, 32'hAAAA,      32'h0,  5'd14, 32'h60,        0, 32'h0};
      vecs[18] = '{1, 1, 0, 1, 5'd12, 32'h0,         32'h0,  5'd12, 32'h101,       1, 32'h60};
      vecs[19] = '{1, 1, 0, 0, 5'd12, 32'h0,         32'h0,  5'd12, 32'h0,         0, 32'h0};

      // Reset held: outputs at reset values.
      repeat (3) @(posedge clk);
      #1;
      check_output("reset redirect", {31'b0, redirect}, 32'h0);
      check_output("reset timer_irq", {31'b0, timer_irq}, 32'h0);
      peek(5'd14, rd); check_output("reset epc", rd, 32'h3000);
      peek(5'd12, rd); check_output("reset status", rd, 32'h0);
      peek(5'd9, rd);  check_output("reset count", rd, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         apply_stimulus(vecs[i].iv, vecs[i].m, vecs[i].s, vecs[i].e, vecs[i].rn, vecs[i].d, vecs[i].pc);
         step();
         check_output($sformatf("vec%0d redirect", i), {31'b0, redirect}, {31'b0, vecs[i].exp_redir});
         if (vecs[i].exp_redir)
            check_output($sformatf("vec%0d redirect_pc", i), redirect_pc, vecs[i].exp_rpc);
         peek(vecs[i].chk_rn, rd);
         check_output($sformatf("vec%0d dout", i), rd, vecs[i].exp_dout);
      end

      // Reset mid-operation drops a pending redirect and clears state at once.
      apply_stimulus(1, 0, 1, 0, 5'd0, 32'h0, 32'h44);
      step();
      check_output("pre-reset redirect", {31'b0, redirect}, 32'h1);
      rst_n = 1'b0;
      #1;
      check_output("async reset redirect", {31'b0, redirect}, 32'h0);
      peek(5'd14, rd); check_output("async reset epc", rd, 32'h3000);
      peek(5'd12, rd); check_output("async reset status", rd, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Count wrap, MTC0 Count overriding the increment.
      do_reset();
      apply_stimulus(1, 1, 0, 0, 5'd9, 32'hFFFF_FFFE, 32'h0);
      step();
      peek(5'd9, rd); check_output("count written", rd, 32'hFFFF_FFFE);
      step();
      peek(5'd9, rd); check_output("count max", rd, 32'hFFFF_FFFF);
      step();
      peek(5'd9, rd); check_output("count wrap", rd, 32'h0);

      // Timer: Compare=20 raises IP[7] the cycle after Count==20, then a valid instr is interrupted.
      do_reset();
      apply_stimulus(1, 1, 0, 0, 5'd9, 32'h0, 32'h0);
      step();
      apply_stimulus(1, 1, 0, 0, 5'd11, 32'd20, 32'h0);
      step();
      apply_stimulus(1, 1, 0, 0, 5'd12, 32'h8001, 32'h0);
      step();
      for (int k = 3; k <= 20; k++) step();
      peek(5'd9, rd); check_output("timer count at compare", rd, 32'd20);
      check_output("timer_irq before", {31'b0, timer_irq}, 32'h0);
      step();
      check_output("timer_irq set", {31'b0, timer_irq}, 32'h1);
      peek(5'd13, rd); check_output("timer cause ip7", rd, 32'h8000);
      apply_stimulus(1, 0, 0, 0, 5'd0, 32'h0, 32'h88);
      step();
      check_output("timer int redirect", {31'b0, redirect}, 32'h1);
      check_output("timer int redirect_pc", redirect_pc, 32'h3000);
      peek(5'd14, rd); check_output("timer int epc", rd, 32'h88);
      peek(5'd13, rd); check_output("timer int cause", rd, 32'h8000);
      peek(5'd12, rd); check_output("timer int status", rd, 32'h8003);
      apply_stimulus(1, 1, 0, 0, 5'd11, 32'h0, 32'h0);
      step();
      check_output("timer_irq cleared", {31'b0, timer_irq}, 32'h0);
      check_output("timer clear no redirect", {31'b0, redirect}, 32'h0);
      peek(5'd13, rd); check_output("timer cleared cause", rd, 32'h0);

      // hw_int[0] one-cycle pulse through the 2-flop synchroniser; interrupt beats SYSCALL.
      do_reset();
      apply_stimulus(1, 1, 0, 0, 5'd12, 32'h0401, 32'h0);
      step();
      @(negedge clk);
      hw_int = 6'b000001;
      step();
      apply_stimulus(1, 0, 0, 0, 5'd0, 32'h0, 32'h70);
      hw_int = 6'b000000;
      step();
      check_output("hwint not yet taken", {31'b0, redirect}, 32'h0);
      peek(5'd13, rd); check_output("hwint cause ip2", rd, 32'h400);
      apply_stimulus(1, 0, 1, 0, 5'd0, 32'h0, 32'h74);
      step();
      check_output("hwint redirect", {31'b0, redirect}, 32'h1);
      check_output("hwint redirect_pc", redirect_pc, 32'h3000);
      peek(5'd14, rd); check_output("hwint epc", rd, 32'h74);
      peek(5'd13, rd); check_output("hwint exccode", rd, 32'h0);
      peek(5'd12, rd); check_output("hwint status exl", rd, 32'h0403);

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
